// File: rtl/regfile_bypass_if.sv
// Bus bundle for regfile_bypass: write port, two read indices, capture strobe
// and the registered/combinational operand outputs.
interface regfile_bypass_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();

    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] WriteReg;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic                  LatchAB;
    logic [DATA_WIDTH-1:0] DataRegA;
    logic [DATA_WIDTH-1:0] DataRegB;
    logic [DATA_WIDTH-1:0] Register2FastTrack;
    logic                  ABValid;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LatchAB,
        input  DataRegA, DataRegB, Register2FastTrack, ABValid
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LatchAB,
        output DataRegA, DataRegB, Register2FastTrack, ABValid
    );

endinterface

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with write-through bypass, latched operand
// registers A/B and a same-cycle bypassed read of port 2. Entry 0 reads as zero.
module regfile_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_bypass_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_reg_a_q, data_reg_a_d;
    logic [DATA_WIDTH-1:0] data_reg_b_q, data_reg_b_d;
    logic                  ab_valid_q, ab_valid_d;
    logic [DATA_WIDTH-1:0] byp_a;
    logic [DATA_WIDTH-1:0] byp_b;
    logic                  write_en;

    // Index 0 is never written, so regs_q[0] stays at its reset value of zero.
    assign write_en = bus.RegWrite && (bus.WriteReg != '0);

    always_comb begin
        byp_a = regs_q[bus.ReadReg1];
        if (bus.ReadReg1 == '0) begin
            byp_a = '0;
        end else if (bus.RegWrite && (bus.WriteReg == bus.ReadReg1)) begin
            byp_a = bus.WriteData;
        end
    end

    always_comb begin
        byp_b = regs_q[bus.ReadReg2];
        if (bus.ReadReg2 == '0) begin
            byp_b = '0;
        end else if (bus.RegWrite && (bus.WriteReg == bus.ReadReg2)) begin
            byp_b = bus.WriteData;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_en) begin
            regs_d[bus.WriteReg] = bus.WriteData;
        end
    end

    // Capture uses the bypassed values so a same-cycle write is seen immediately.
    always_comb begin
        data_reg_a_d = data_reg_a_q;
        data_reg_b_d = data_reg_b_q;
        ab_valid_d   = ab_valid_q;
        if (bus.LatchAB) begin
            data_reg_a_d = byp_a;
            data_reg_b_d = byp_b;
            ab_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            data_reg_a_q <= '0;
            data_reg_b_q <= '0;
            ab_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            data_reg_a_q <= data_reg_a_d;
            data_reg_b_q <= data_reg_b_d;
            ab_valid_q   <= ab_valid_d;
        end
    end

    assign bus.DataRegA           = data_reg_a_q;
    assign bus.DataRegB           = data_reg_b_q;
    assign bus.ABValid            = ab_valid_q;
    assign bus.Register2FastTrack = rst_n ? byp_b : '0;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed, table-driven bench for regfile_bypass with hand-written sequences
// for reset behaviour and the post-reset sweep.
module tb_regfile_bypass;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          latch;
        logic [DW-1:0] exp_fast;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic          exp_valid;
    } vec_t;

    localparam int NVEC = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    regfile_bypass_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                                 input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic latch);
        bus.RegWrite  = we;
        bus.WriteReg  = wr;
        bus.WriteData = wd;
        bus.ReadReg1  = r1;
        bus.ReadReg2  = r2;
        bus.LatchAB   = latch;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Each vector: fast path is checked mid-cycle, latched outputs after the edge.
    function automatic vec_t mk(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic latch,
                                input logic [DW-1:0] ef, input logic [DW-1:0] ea,
                                input logic [DW-1:0] eb, input logic ev);
        vec_t v;
        v.we = we; v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2; v.latch = latch;
        v.exp_fast = ef; v.exp_a = ea; v.exp_b = eb; v.exp_valid = ev;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = mk(1, 3,  32'h12345678, 0,  0,  0, 32'h0,        32'h0,        32'h0,        0);
        vecs[1]  = mk(0, 0,  32'h0,        3,  3,  1, 32'h12345678, 32'h12345678, 32'h12345678, 1);
        vecs[2]  = mk(1, 7,  32'h11,       0,  0,  0, 32'h0,        32'h12345678, 32'h12345678, 1);
        vecs[3]  = mk(1, 7,  32'h22,       3,  7,  1, 32'h22,       32'h12345678, 32'h22,       1);
        vecs[4]  = mk(1, 0,  32'hFFFFFFFF, 0,  0,  1, 32'h0,        32'h0,        32'h0,        1);
        vecs[5]  = mk(0, 0,  32'h0,        0,  0,  1, 32'h0,        32'h0,        32'h0,        1);
        vecs[6]  = mk(1, 4,  32'h44,       0,  4,  0, 32'h44,       32'h0,        32'h0,        1);
        vecs[7]  = mk(0, 0,  32'h0,        3,  4,  1, 32'h44,       32'h12345678, 32'h44,       1);
        vecs[8]  = mk(1, 3,  32'hAA,       7,  3,  0, 32'hAA,       32'h12345678, 32'h44,       1);
        vecs[9]  = mk(0, 0,  32'h0,        4,  7,  0, 32'h22,       32'h12345678, 32'h44,       1);
        vecs[10] = mk(0, 0,  32'h0,        1,  3,  0, 32'hAA,       32'h12345678, 32'h44,       1);
        vecs[11] = mk(0, 0,  32'h0,        3,  3,  1, 32'hAA,       32'hAA,       32'hAA,       1);
        vecs[12] = mk(1, 9,  32'h99,       9,  9,  1, 32'h99,       32'h99,       32'h99,       1);
        vecs[13] = mk(1, 31, 32'hCAFEF00D, 31, 31, 0, 32'hCAFEF00D, 32'h99,       32'h99,       1);
        vecs[14] = mk(0, 0,  32'h0,        31, 0,  1, 32'h0,        32'hCAFEF00D, 32'h0,        1);

        // Reset held two cycles with a write pending on r5.
        rst_n = 1'b0;
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 5, 1);
        @(posedge clk);
        #1 checkOutput("rst_fast", bus.Register2FastTrack, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_a", bus.DataRegA, 32'h0);
        checkOutput("rst_b", bus.DataRegB, 32'h0);
        checkOutput("rst_valid", {31'h0, bus.ABValid}, 32'h0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 5, 0);
        #1 checkOutput("rst_r5_dropped", bus.Register2FastTrack, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2, vecs[i].latch);
            #2 checkOutput($sformatf("vec%0d_fast", i), bus.Register2FastTrack, vecs[i].exp_fast);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_a", i), bus.DataRegA, vecs[i].exp_a);
            checkOutput($sformatf("vec%0d_b", i), bus.DataRegB, vecs[i].exp_b);
            checkOutput($sformatf("vec%0d_valid", i), {31'h0, bus.ABValid}, {31'h0, vecs[i].exp_valid});
        end

        // Fill r1..r31 with their own index, then capture two of them.
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1, AW'(i), DW'(i), 0, 0, 0);
            @(posedge clk);
            #1;
        end
        applyStimulus(0, 0, 32'h0, 5, 31, 1);
        @(posedge clk);
        #1;
        checkOutput("fill_a", bus.DataRegA, 32'd5);
        checkOutput("fill_b", bus.DataRegB, 32'd31);

        // Single-cycle reset mid-run, with a write and capture competing.
        rst_n = 1'b0;
        applyStimulus(1, 10, 32'hBAD, 5, 10, 1);
        #1 checkOutput("mid_rst_fast", bus.Register2FastTrack, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_a", bus.DataRegA, 32'h0);
        checkOutput("mid_rst_b", bus.DataRegB, 32'h0);
        checkOutput("mid_rst_valid", {31'h0, bus.ABValid}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 32'h0, 0, AW'(i), 0);
            #1 checkOutput($sformatf("sweep_r%0d", i), bus.Register2FastTrack, 32'h0);
        end
        @(posedge clk);
        #1 checkOutput("sweep_valid_hold", {31'h0, bus.ABValid}, 32'h0);

        // First legal write after reset release.
        applyStimulus(1, 10, 32'h1234, 0, 10, 0);
        #1 checkOutput("post_rst_fast", bus.Register2FastTrack, 32'h1234);
        @(posedge clk);
        #1;
        applyStimulus(0, 0, 32'h0, 10, 10, 1);
        @(posedge clk);
        #1;
        checkOutput("post_rst_a", bus.DataRegA, 32'h1234);
        checkOutput("post_rst_b", bus.DataRegB, 32'h1234);
        checkOutput("post_rst_valid", {31'h0, bus.ABValid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
